program_loader: RTL and testbench

- Upstream feeder of the instruction-fetch stage.
- Receives a program as a byte stream over a valid/ready handshake and assembles each 4 bytes into a 32-bit little-endian instruction word.
- Drives the instruction memory write port (rw, PC_write, instruction_in, reset_memory).
- Holds the core PC in reset until the whole program has been written.

---
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Function : Streams a byte-wise program into instruction memory as 32-bit
//             little-endian words and holds the core PC until loading is done.
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int PC_SIZE = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_abort,
  input  logic [PC_SIZE:0]   load_length,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               rw,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               reset_memory,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic [7:0]         checksum
);

  localparam logic [PC_SIZE:0] c_MAX_LEN = {1'b1, {PC_SIZE{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RECEIVE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PC_SIZE:0] r_len;
  logic [PC_SIZE:0] r_addr;
  logic [1:0]       r_cnt;
  logic [23:0]      r_word;

  logic             w_start;
  logic             w_abort;
  logic             w_accept;
  logic [PC_SIZE:0] w_addr_inc;

  assign w_start    = load_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_abort    = load_abort &&
                      (r_state == S_CLEAR || r_state == S_RECEIVE || r_state == S_WRITE);
  assign w_accept   = byte_valid && byte_ready && !load_abort;
  assign w_addr_inc = r_addr + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    byte_ready   = 1'b0;
    rw           = 1'b0;
    reset_memory = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        reset_memory = !load_abort;
        w_next       = (r_len == '0) ? S_DONE : S_RECEIVE;
      end
      S_RECEIVE: begin
        byte_ready = 1'b1;
        if (w_accept && r_cnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        rw     = !load_abort;
        w_next = (w_addr_inc == r_len) ? S_DONE : S_RECEIVE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides any transition, including a write in flight.
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len          <= '0;
      r_addr         <= '0;
      r_cnt          <= 2'd0;
      r_word         <= 24'd0;
      PC_write       <= '0;
      instruction_in <= 32'd0;
      core_hold      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= 8'd0;
    end else if (w_start) begin
      r_len     <= (load_length > c_MAX_LEN) ? c_MAX_LEN : load_length;
      r_addr    <= '0;
      r_cnt     <= 2'd0;
      checksum  <= 8'd0;
      done      <= 1'b0;
      busy      <= 1'b1;
      core_hold <= 1'b1;
    end else if (w_abort) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_len == '0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            core_hold <= 1'b0;
          end
        end
        S_RECEIVE: begin
          if (w_accept) begin
            checksum <= checksum ^ byte_data;
            r_cnt    <= r_cnt + 2'd1;
            case (r_cnt)
              2'd0: r_word[7:0]   <= byte_data;
              2'd1: r_word[15:8]  <= byte_data;
              2'd2: r_word[23:16] <= byte_data;
              default: begin
                // Final byte: present the full word and address for WRITE.
                instruction_in <= {byte_data, r_word};
                PC_write       <= r_addr[PC_SIZE-1:0];
              end
            endcase
          end
        end
        S_WRITE: begin
          r_addr <= w_addr_inc;
          r_cnt  <= 2'd0;
          if (w_addr_inc == r_len) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            core_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Function : Scoreboard bench for program_loader with directed load vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int PC_SIZE = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               load_start = 1'b0;
  logic               load_abort = 1'b0;
  logic [PC_SIZE:0]   load_length = '0;
  logic [7:0]         byte_data = 8'd0;
  logic               byte_valid = 1'b0;
  logic               byte_ready;
  logic               rw;
  logic [PC_SIZE-1:0] PC_write;
  logic [31:0]        instruction_in;
  logic               reset_memory;
  logic               core_hold;
  logic               busy;
  logic               done;
  logic [7:0]         checksum;

  program_loader #(.PC_SIZE(PC_SIZE)) dut (
    .clock          (clock),
    .reset          (reset),
    .load_start     (load_start),
    .load_abort     (load_abort),
    .load_length    (load_length),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .rw             (rw),
    .PC_write       (PC_write),
    .instruction_in (instruction_in),
    .reset_memory   (reset_memory),
    .core_hold      (core_hold),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PC_SIZE-1:0] addr;
    logic [31:0]        data;
  } wr_t;

  wr_t      exp_q[$];
  int       n_tests  = 0;
  int       n_fail   = 0;
  int       rm_count = 0;
  int       wr_count = 0;
  logic [7:0] csum   = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write pops the next expected (address, word).
  always @(negedge clock) begin
    wr_t e;
    if (reset) begin
      if (reset_memory) rm_count++;
      if (rw) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got PC_write=%0d data=0x%08h, expected no write",
                   PC_write, instruction_in);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {28'd0, PC_write}, {28'd0, e.addr});
          check("write_data", instruction_in, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [PC_SIZE:0] len);
    load_length = len;
    load_start  = 1'b1;
    tick();
    load_start  = 1'b0;
    csum        = 8'd0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got byte_ready=0 for %0d cycles, expected 1", t);
    end
    tick();
    csum       = csum ^ b;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  initial begin : stim
    logic [31:0] bp_word;
    int rm0;
    int wr0;

    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] bp_word;
    int rm0;
    int wr0;

    // Reset asserted and released, no start.
    tick();
    tick();
    check("rst_hold_in_reset", core_hold, 1'b1);
    reset = 1'b1;
    tick();
    check("rst_core_hold", core_hold, 1'b1);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_checksum", checksum, 8'h00);

    // Basic two-word load, bytes back-to-back.
    exp_q.push_back('{addr: 4'd0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 4'd1, data: 32'h0010_0093});
    rm0 = rm_count;
    start(5'd2);
    check("basic_reset_memory", reset_memory, 1'b1);
    check("basic_busy", busy, 1'b1);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    check("basic_rw_latency", rw, 1'b1);
    tick();
    check("basic_done", done, 1'b1);
    check("basic_core_hold", core_hold, 1'b0);
    check("basic_busy_end", busy, 1'b0);
    check("basic_checksum", checksum, 8'h13 ^ 8'h93 ^ 8'h10);
    check("basic_clear_pulses", rm_count - rm0, 1);
    check("basic_queue_empty", exp_q.size(), 0);

    // Backpressure: two idle cycles with junk data between accepted bytes.
    bp_word = 32'hDEAD_BEEF;
    exp_q.push_back('{addr: 4'd0, data: bp_word});
    start(5'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("bp_no_early_write", rw, 1'b0);
      send(bp_word[8*i +: 8]);
      if (i < 3) begin
        byte_data = 8'h55;
        repeat (2) tick();
      end
    end
    check("bp_rw_latency", rw, 1'b1);
    tick();
    check("bp_done", done, 1'b1);
    check("bp_checksum", checksum, 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
    repeat (3) tick();
    check("bp_done_held", done, 1'b1);
    check("bp_queue_empty", exp_q.size(), 0);

    // Zero length: CLEAR then DONE, no write.
    rm0 = rm_count;
    wr0 = wr_count;
    start(5'd0);
    check("zero_reset_memory", reset_memory, 1'b1);
    check("zero_done_low", done, 1'b0);
    tick();
    check("zero_done", done, 1'b1);
    check("zero_core_hold", core_hold, 1'b0);
    check("zero_clear_pulses", rm_count - rm0, 1);
    check("zero_no_write", wr_count - wr0, 0);

    // Oversized length clamps to the 16-word memory depth.
    wr0 = wr_count;
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{addr: 4'(i), data: 32'hA500_0000 | 32'(i)});
    start(5'd20);
    for (int i = 0; i < 16; i++) send_word(32'hA500_0000 | 32'(i));
    tick();
    check("max_done", done, 1'b1);
    check("max_last_addr", {28'd0, PC_write}, 32'd15);
    check("max_write_count", wr_count - wr0, 16);
    check("max_queue_empty", exp_q.size(), 0);

    // Abort after two bytes of the second word.
    exp_q.push_back('{addr: 4'd0, data: 32'h1122_3344});
    start(5'd3);
    send_word(32'h1122_3344);
    send(8'h01);
    send(8'h02);
    wr0 = wr_count;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_core_hold", core_hold, 1'b1);
    check("abort_byte_ready", byte_ready, 1'b0);
    check("abort_checksum_kept", checksum, 8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11 ^ 8'h01 ^ 8'h02);
    repeat (5) tick();
    check("abort_no_write", wr_count - wr0, 0);

    // Reload after abort starts at address 0.
    exp_q.push_back('{addr: 4'd0, data: 32'hCAFE_F00D});
    start(5'd1);
    send_word(32'hCAFE_F00D);
    tick();
    check("reload_done", done, 1'b1);
    check("reload_addr", {28'd0, PC_write}, 32'd0);
    check("reload_queue_empty", exp_q.size(), 0);

    // Start ignored while busy, then asynchronous reset mid-RECEIVE.
    start(5'd2);
    send(8'hAA);
    send(8'h55);
    load_length = 5'd1;
    load_start  = 1'b1;
    tick();
    load_start  = 1'b0;
    check("busy_start_ignored_ready", byte_ready, 1'b1);
    check("busy_start_ignored_csum", checksum, 8'hAA ^ 8'h55);
    #3;
    reset = 1'b0;
    #1;
    check("async_core_hold", core_hold, 1'b1);
    check("async_busy", busy, 1'b0);
    check("async_byte_ready", byte_ready, 1'b0);
    check("async_checksum", checksum, 8'h00);
    check("async_instr", instruction_in, 32'd0);
    check("async_pc", {28'd0, PC_write}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle_ready", byte_ready, 1'b0);
    check("post_reset_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
